key_event_decoder: RTL and testbench

//  Consumes the debounced key level/strobe from key_debounce and classifies presses

---
 rtl/key_event_decoder.sv | 75 +++++++
 tb/tb_key_event_decoder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_decoder.sv
// key_event_decoder: classifies debounced key strobes into short, double, long and repeat pulses
module key_event_decoder #(
   parameter int LONG_CYC   = 50_000_000,
   parameter int DCLK_CYC   = 15_000_000,
   parameter int REPEAT_CYC = 10_000_000,
   parameter int CNT_W      = 26
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic key_value,
   input  logic key_flag,
   output logic short_press,
   output logic double_click,
   output logic long_press,
   output logic long_repeat,
   output logic busy
);
   typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, LONG} state_t;
   localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYC - 1);
   localparam logic [CNT_W-1:0] DCLK_MAX = CNT_W'(DCLK_CYC - 1);
   localparam logic [CNT_W-1:0] REP_MAX  = CNT_W'(REPEAT_CYC - 1);
   state_t state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic press, rel, long_to, dclk_to, rep_to;
   logic sp_d, dc_d, lp_d, lr_d;
   assign press   = key_flag & ~key_value;
   assign rel     = key_flag & key_value;
   assign long_to = cnt == LONG_MAX;
   assign dclk_to = cnt == DCLK_MAX;
   assign rep_to  = cnt == REP_MAX;
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end
   // events are tested before timeouts so a coincident event always wins
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = press ? PRESS1 : IDLE;
         PRESS1:  state_nxt = rel ? WAIT2 : long_to ? LONG : PRESS1;
         WAIT2:   state_nxt = press ? PRESS2 : dclk_to ? IDLE : WAIT2;
         PRESS2:  state_nxt = rel ? IDLE : PRESS2;
         LONG:    state_nxt = rel ? IDLE : LONG;
         default: state_nxt = IDLE;
      endcase
      cnt_nxt = (state_nxt != state || state == IDLE || state == PRESS2 || (state == LONG && rep_to))
              ? '0 : cnt + CNT_W'(1);
   end
   always_comb begin
      sp_d = state == WAIT2  && !press && dclk_to;
      dc_d = state == PRESS2 && rel;
      lp_d = state == PRESS1 && !rel && long_to;
      lr_d = state == LONG   && !rel && rep_to;
   end
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         short_press  <= 1'b0;
         double_click <= 1'b0;
         long_press   <= 1'b0;
         long_repeat  <= 1'b0;
         busy         <= 1'b0;
      end else begin
         short_press  <= sp_d;
         double_click <= dc_d;
         long_press   <= lp_d;
         long_repeat  <= lr_d;
         busy         <= state_nxt != IDLE;
      end
   end
endmodule

// File: tb/tb_key_event_decoder.sv
// tb_key_event_decoder: randomized key sequences scored against an event-level timing model
module tb_key_event_decoder;
   localparam int L = 100;
   localparam int D = 40;
   localparam int R = 20;
   logic sys_clk = 1'b0;
   logic sys_rst_n, key_value, key_flag;
   logic short_press, double_click, long_press, long_repeat, busy;
   bit   lvl;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   typedef struct {int kind; int cyc;} exp_t;
   exp_t exp_q[$];
   int   bs_q[$];
   int   be_q[$];
   logic [3:0] pv;
   bit   eb;
   exp_t e;

   key_event_decoder #(.LONG_CYC(L), .DCLK_CYC(D), .REPEAT_CYC(R), .CNT_W(8)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_value(key_value), .key_flag(key_flag),
      .short_press(short_press), .double_click(double_click), .long_press(long_press),
      .long_repeat(long_repeat), .busy(busy));

   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   // kinds: 0 short_press, 1 double_click, 2 long_press, 3 long_repeat
   task automatic push_exp(input int k, input int c, input int hz);
      exp_t x;
      x.kind = k;
      x.cyc  = c;
      if (c <= hz) exp_q.push_back(x);
   endtask

   task automatic push_busy(input int b, input int en, input int hz);
      if (b <= hz) begin
         bs_q.push_back(b);
         be_q.push_back(en < hz + 1 ? en : hz + 1);
      end
   endtask

   // walks level-change events; hz is the last cycle before a reset cuts the sequence
   task automatic model(input int et[$], input bit ev[$], input int hz);
      int ph = 0;
      int t0 = 0;
      int bsv = 0;
      for (int i = 0; i < et.size(); i++) begin
         int t;
         t = et[i];
         case (ph)
            0: if (!ev[i]) begin ph = 1; t0 = t; bsv = t + 1; end
            1: if (ev[i]) begin
                  if (t <= t0 + L) begin ph = 2; t0 = t; end
                  else begin
                     push_exp(2, t0 + L + 1, hz);
                     for (int k = 1; t0 + L + k * R < t; k++) push_exp(3, t0 + L + k * R + 1, hz);
                     push_busy(bsv, t + 1, hz);
                     ph = 0;
                  end
               end
            2: if (!ev[i]) begin
                  if (t <= t0 + D) ph = 3;
                  else begin
                     push_exp(0, t0 + D + 1, hz);
                     push_busy(bsv, t0 + D + 1, hz);
                     ph = 1; t0 = t; bsv = t + 1;
                  end
               end
            default: if (ev[i]) begin push_exp(1, t + 1, hz); push_busy(bsv, t + 1, hz); ph = 0; end
         endcase
      end
      if (ph == 2) begin
         push_exp(0, t0 + D + 1, hz);
         push_busy(bsv, t0 + D + 1, hz);
      end else if (ph == 1) begin
         push_exp(2, t0 + L + 1, hz);
         for (int k = 1; t0 + L + k * R + 1 <= hz; k++) push_exp(3, t0 + L + k * R + 1, hz);
         push_busy(bsv, hz + 1, hz);
      end else if (ph == 3) push_busy(bsv, hz + 1, hz);
   endtask

   always @(posedge sys_clk) begin
      #1;
      pv = {long_repeat, long_press, double_click, short_press};
      while (be_q.size() > 0 && be_q[0] <= cyc) begin
         void'(bs_q.pop_front());
         void'(be_q.pop_front());
      end
      eb = 1'b0;
      foreach (bs_q[i]) if (cyc >= bs_q[i] && cyc < be_q[i]) eb = 1'b1;
      checks++;
      if (busy !== eb) begin
         errors++;
         $display("FAIL busy: got %b at cycle %0d, want %b", busy, cyc, eb);
      end
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         e = exp_q.pop_front();
         checks++;
         errors++;
         $display("FAIL missed: pulse kind %0d absent, want it at cycle %0d", e.kind, e.cyc);
      end
      if (pv != 4'b0) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected: got pulses %b at cycle %0d, want none", pv, cyc);
         end else begin
            e = exp_q.pop_front();
            if (pv != 4'(1 << e.kind) || cyc != e.cyc) begin
               errors++;
               $display("FAIL pulse: got %b at cycle %0d, want %b at cycle %0d", pv, cyc, 4'(1 << e.kind), e.cyc);
            end
         end
      end
   end

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   // noise: flags repeating the current level and level toggles without a flag
   task automatic glitch();
      case ($urandom_range(0, 7))
         0:       begin key_flag = 1'b1; key_value = lvl; end
         1:       begin key_flag = 1'b0; key_value = ~lvl; end
         default: begin key_flag = 1'b0; key_value = lvl; end
      endcase
   endtask

   task automatic check_zero(input string nm);
      checks++;
      if ({short_press, double_click, long_press, long_repeat, busy} !== 5'b0) begin
         errors++;
         $display("FAIL %s: got outputs %b, want 00000", nm,
                  {short_press, double_click, long_press, long_repeat, busy});
      end
   endtask

   task automatic apply_reset();
      #2 sys_rst_n = 1'b0;
      #1 check_zero("async_reset");
      key_flag = 1'b0;
      key_value = 1'b1;
      lvl = 1'b1;
      repeat (3) @(posedge sys_clk);
      #2 sys_rst_n = 1'b1;
      step();
      repeat (2 * L) begin glitch(); step(); end
   endtask

   task automatic run(input int et[$], input bit ev[$], input int rc);
      int hz;
      int last;
      hz   = rc > 0 ? rc : 1_000_000_000;
      last = rc > 0 ? rc : et[et.size() - 1] + D + 10;
      model(et, ev, hz);
      while (cyc <= last) begin
         if (et.size() > 0 && et[0] == cyc) begin
            key_flag = 1'b1;
            key_value = ev[0];
            lvl = ev[0];
            void'(et.pop_front());
            void'(ev.pop_front());
         end else glitch();
         if (rc > 0 && cyc == rc) begin
            apply_reset();
            break;
         end
         step();
      end
      key_flag = 1'b0;
   endtask

   task automatic rand_scn();
      int et[$];
      bit ev[$];
      int t;
      int n;
      t = cyc + int'($urandom_range(1, 5));
      n = int'($urandom_range(1, 3));
      for (int p = 0; p < n; p++) begin
         int h;
         int g;
         case ($urandom_range(0, 3))
            0:       h = int'($urandom_range(1, L - 1));
            1:       h = L;
            2:       h = L + 1;
            default: h = int'($urandom_range(L + 2, L + 3 * R));
         endcase
         case ($urandom_range(0, 3))
            0:       g = int'($urandom_range(1, D - 1));
            1:       g = D;
            2:       g = D + 1;
            default: g = int'($urandom_range(D + 2, D + 20));
         endcase
         et.push_back(t);
         ev.push_back(1'b0);
         t += h;
         et.push_back(t);
         ev.push_back(1'b1);
         t += g;
      end
      run(et, ev, 0);
   endtask

   initial begin
      int s;
      sys_rst_n = 1'b0;
      key_value = 1'b1;
      key_flag  = 1'b0;
      lvl       = 1'b1;
      repeat (3) @(posedge sys_clk);
      #1 check_zero("reset_state");
      #1 sys_rst_n = 1'b1;
      step();
      s = cyc; run('{s + 10, s + 30}, '{1'b0, 1'b1}, 0);
      s = cyc; run('{s + 10, s + 30, s + 50, s + 60}, '{1'b0, 1'b1, 1'b0, 1'b1}, 0);
      s = cyc; run('{s + 10, s + 200}, '{1'b0, 1'b1}, 0);
      s = cyc; run('{s + 10, s + 110, s + 150, s + 160}, '{1'b0, 1'b1, 1'b0, 1'b1}, 0);
      s = cyc; run('{s + 5}, '{1'b0}, s + L + 35);
      s = cyc; run('{s + 5, s + 25}, '{1'b0, 1'b1}, s + 45);
      for (int i = 0; i < 12; i++) rand_scn();
      repeat (10) step();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL leftover: got %0d pulses never seen, want 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
